// File: rtl/ltl_enc_pkg.sv
// Shared types and helpers for the LTL monitor symbol encoder.
package ltl_enc_pkg;

  localparam int unsigned SYM_W  = 8;
  localparam int unsigned PROP_W = 4;
  localparam int unsigned SEQ_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    MRST,
    STREAM,
    DRAIN
  } enc_state_e;

  function automatic logic [SYM_W-1:0] build_symbol(input logic [PROP_W-1:0] props,
                                                    input logic [SEQ_W-1:0]  seq);
    return {props, seq};
  endfunction

endpackage

// File: rtl/ltl_enc_fifo.sv
// Synchronous event FIFO; an extra pointer bit separates full from empty.
module ltl_enc_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_comb begin
    empty_o = (wr_ptr == rd_ptr);
    full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    rdata_o = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i && !empty_o) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem[wr_ptr[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ltl_symbol_encoder.sv
// Packs buffered proposition events into monitor symbols with session reset sequencing.
// Optional session statistics outputs are built when LTL_ENC_STATS_EN is defined.
module ltl_symbol_encoder
  import ltl_enc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              flush_i,
  input  logic              evt_valid_i,
  output logic              evt_ready_o,
  input  logic [PROP_W-1:0] evt_props_i,
  output logic              mon_reset_o,
  output logic              mon_run_o,
  output logic [SYM_W-1:0]  mon_symbols_o,
  output logic              busy_o
`ifdef LTL_ENC_STATS_EN
  ,
  output logic [31:0]       sym_count_o,
  output logic [31:0]       stall_count_o
`endif
);

  localparam int unsigned    CW        = $clog2(RST_CYCLES + 1);
  localparam logic [CW-1:0]  RST_LIMIT = CW'(RST_CYCLES);

  enc_state_e        state;
  logic [CW-1:0]     rst_cnt;
  logic [SEQ_W-1:0]  seq;
  logic [PROP_W-1:0] head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              clear;
  logic              rst_done;

  // Ready is also gated by flush_i so nothing is accepted that a flush would discard.
  always_comb begin
    rst_done    = (rst_cnt >= RST_LIMIT);
    evt_ready_o = ((state == MRST) || (state == STREAM)) && !full && !flush_i;
    push        = evt_valid_i && evt_ready_o;
    pop         = 1'b0;
    clear       = 1'b0;
    busy_o      = (state != IDLE);
    case (state)
      IDLE:   clear = 1'b1;
      MRST: begin
        clear = flush_i;
        pop   = !empty && rst_done && !flush_i;
      end
      STREAM: pop = !empty;
      DRAIN:  pop = !empty;
      default: clear = 1'b1;
    endcase
  end

  ltl_enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PROP_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (evt_props_i),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // The MRST->STREAM edge pops and emits symbol 0 while dropping the monitor reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      rst_cnt       <= '0;
      seq           <= '0;
      mon_reset_o   <= 1'b1;
      mon_run_o     <= 1'b0;
      mon_symbols_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          mon_reset_o <= 1'b1;
          mon_run_o   <= 1'b0;
          if (enable_i && !flush_i) begin
            state   <= MRST;
            rst_cnt <= '0;
            seq     <= '0;
          end
        end
        MRST: begin
          mon_reset_o <= 1'b1;
          mon_run_o   <= 1'b0;
          seq         <= '0;
          if (!rst_done) rst_cnt <= rst_cnt + 1'b1;
          if (flush_i) begin
            state <= IDLE;
          end else if (pop) begin
            state         <= STREAM;
            mon_reset_o   <= 1'b0;
            mon_run_o     <= 1'b1;
            mon_symbols_o <= build_symbol(head, '0);
            seq           <= SEQ_W'(1);
          end
        end
        STREAM: begin
          mon_reset_o <= 1'b0;
          mon_run_o   <= pop;
          if (pop) begin
            mon_symbols_o <= build_symbol(head, seq);
            seq           <= seq + 1'b1;
          end
          if (flush_i) state <= DRAIN;
        end
        DRAIN: begin
          mon_run_o <= pop;
          if (pop) begin
            mon_reset_o   <= 1'b0;
            mon_symbols_o <= build_symbol(head, seq);
            seq           <= seq + 1'b1;
          end else begin
            mon_reset_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          mon_reset_o <= 1'b1;
          mon_run_o   <= 1'b0;
        end
      endcase
    end
  end

`ifdef LTL_ENC_STATS_EN
  logic stall;

  always_comb begin
    stall = evt_valid_i && !evt_ready_o && ((state == MRST) || (state == STREAM));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sym_count_o   <= '0;
      stall_count_o <= '0;
    end else if (state == IDLE && enable_i && !flush_i) begin
      sym_count_o   <= '0;
      stall_count_o <= '0;
    end else begin
      if (pop && (sym_count_o != '1))     sym_count_o   <= sym_count_o + 1'b1;
      if (stall && (stall_count_o != '1)) stall_count_o <= stall_count_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ltl_symbol_encoder.sv
// Directed bench for ltl_symbol_encoder (FIFO_DEPTH=4, RST_CYCLES=8).
module tb_ltl_symbol_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       flush = 1'b0;
  logic       evt_valid = 1'b0;
  logic [3:0] evt_props = 4'h0;
  logic       evt_ready;
  logic       mon_reset;
  logic       mon_run;
  logic [7:0] mon_symbols;
  logic       busy;
`ifdef LTL_ENC_STATS_EN
  logic [31:0] sym_count;
  logic [31:0] stall_count;
`endif

  ltl_symbol_encoder #(
    .FIFO_DEPTH (4),
    .RST_CYCLES (8)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .enable_i      (enable),
    .flush_i       (flush),
    .evt_valid_i   (evt_valid),
    .evt_ready_o   (evt_ready),
    .evt_props_i   (evt_props),
    .mon_reset_o   (mon_reset),
    .mon_run_o     (mon_run),
    .mon_symbols_o (mon_symbols),
    .busy_o        (busy)
`ifdef LTL_ENC_STATS_EN
    ,
    .sym_count_o   (sym_count),
    .stall_count_o (stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] props;
    logic [7:0] exp_sym;
  } vec_t;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         run_count = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_seq = 4'h0;
  logic [7:0] emitted[$];
  int         emit_cyc[$];
  logic       prev_reset = 1'b1;
  logic       last_acc = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Sample handshake before the edge, outputs 1ns after it; score every emitted symbol.
  task automatic tick();
    @(negedge clk);
    last_acc = evt_valid && evt_ready;
    if (last_acc) exp_q.push_back(evt_props);
    prev_reset = mon_reset;
    @(posedge clk);
    #1;
    cyc++;
    if (mon_run) begin
      run_count++;
      emitted.push_back(mon_symbols);
      emit_cyc.push_back(cyc);
      check("run_reset_low", {31'd0, mon_reset}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_run actual=0x%0h required=no_symbol", mon_symbols);
      end else begin
        check("symbol", {24'd0, mon_symbols}, {24'd0, exp_q.pop_front(), exp_seq});
        exp_seq = exp_seq + 4'h1;
      end
    end
  endtask

  task automatic wait_run(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (mon_run) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL wait_run_timeout actual=no_run required=run_within_%0d", budget);
    end
  endtask

  task automatic end_session();
    enable = 1'b0;
    flush  = 1'b1;
    for (int i = 0; i < 20 && busy; i++) tick();
    flush = 1'b0;
    tick();
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_reset", {31'd0, mon_reset}, 32'd1);
    check("end_run", {31'd0, mon_run}, 32'd0);
  endtask

  vec_t       tbl[20];
  logic [7:0] exp4[6];
  bit         seen;
  int         sent;
  int         sent_at_first;
  bit         full_checked;

  initial begin
    for (int i = 0; i < 20; i++) begin
      tbl[i].props   = 4'h3;
      tbl[i].exp_sym = {4'h3, 4'(i)};
    end
    exp4 = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};

    // Reset state, then idle with enable low.
    repeat (3) tick();
    check("rst_reset", {31'd0, mon_reset}, 32'd1);
    check("rst_run", {31'd0, mon_run}, 32'd0);
    check("rst_sym", {24'd0, mon_symbols}, 32'h00);
    check("rst_ready", {31'd0, evt_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_reset", {31'd0, mon_reset}, 32'd1);
      check("idle_ready", {31'd0, evt_ready}, 32'd0);
      check("idle_run", {31'd0, mon_run}, 32'd0);
    end

    // Enable and flush together in IDLE: flush wins.
    enable = 1'b1;
    flush  = 1'b1;
    repeat (4) tick();
    check("en_flush_busy", {31'd0, busy}, 32'd0);
    check("en_flush_reset", {31'd0, mon_reset}, 32'd1);
    enable = 1'b0;
    flush  = 1'b0;
    tick();

    // Single event 0xA at cycle 5 of the session.
    exp_seq = 4'h0;
    enable  = 1'b1;
    repeat (5) tick();
    check("mrst_busy", {31'd0, busy}, 32'd1);
    check("mrst_reset", {31'd0, mon_reset}, 32'd1);
    evt_valid = 1'b1;
    evt_props = 4'hA;
    tick();
    check("mrst_accept", {31'd0, last_acc}, 32'd1);
    evt_valid = 1'b0;
    enable    = 1'b0;
    wait_run(30, seen);
    if (seen) begin
      check("first_sym", {24'd0, mon_symbols}, 32'hA0);
      check("first_prev_reset", {31'd0, prev_reset}, 32'd1);
    end
    tick();
    check("empty_run_low", {31'd0, mon_run}, 32'd0);
    check("empty_sym_hold", {24'd0, mon_symbols}, 32'hA0);
    check("stream_no_enable", {31'd0, busy}, 32'd1);
    end_session();

    // 20 back-to-back events, seq wraps after 0x3F.
    exp_seq = 4'h0;
    emitted.delete();
    emit_cyc.delete();
    enable = 1'b1;
    sent   = 0;
    for (int i = 0; i < 200 && emitted.size() < 20; i++) begin
      evt_valid = (sent < 20);
      evt_props = tbl[(sent < 20) ? sent : 19].props;
      tick();
      if (last_acc) sent++;
    end
    evt_valid = 1'b0;
    check("b2b_count", emitted.size(), 32'd20);
    if (emitted.size() >= 20) begin
      for (int i = 0; i < 20; i++) begin
        check("b2b_sym", {24'd0, emitted[i]}, {24'd0, tbl[i].exp_sym});
        check("b2b_consecutive", emit_cyc[i] - emit_cyc[0], i);
      end
    end
    tick();
    check("b2b_done_run", {31'd0, mon_run}, 32'd0);
    end_session();

    // Six events offered during MRST: four fill the FIFO, two follow once streaming.
    exp_seq = 4'h0;
    emitted.delete();
    emit_cyc.delete();
    enable        = 1'b1;
    sent          = 0;
    sent_at_first = -1;
    full_checked  = 1'b0;
    for (int i = 0; i < 100 && emitted.size() < 6; i++) begin
      evt_valid = (sent < 6);
      evt_props = 4'(sent + 1);
      tick();
      if (last_acc) sent++;
      if (sent_at_first < 0 && mon_run) sent_at_first = sent;
      if (sent == 4 && !full_checked && mon_reset) begin
        full_checked = 1'b1;
        check("full_ready_low", {31'd0, evt_ready}, 32'd0);
      end
    end
    evt_valid = 1'b0;
    check("full_seen", {31'd0, full_checked}, 32'd1);
    check("accepted_before_stream", sent_at_first, 32'd4);
    check("fill_count", emitted.size(), 32'd6);
    if (emitted.size() >= 6) begin
      for (int i = 0; i < 6; i++) check("fill_order", {24'd0, emitted[i]}, {24'd0, exp4[i]});
    end
    end_session();

    // Flush with three events buffered: three more symbols, then IDLE.
    exp_seq   = 4'h0;
    enable    = 1'b1;
    evt_valid = 1'b1;
    evt_props = 4'h7;
    wait_run(30, seen);
    repeat (3) tick();
    check("buffered_before_flush", exp_q.size(), 32'd3);
    flush = 1'b1;
    #1;
    check("flush_ready_low", {31'd0, evt_ready}, 32'd0);
    run_count = 0;
    for (int i = 0; i < 20 && busy; i++) tick();
    check("flush_pulses", run_count, 32'd3);
    check("flush_idle_reset", {31'd0, mon_reset}, 32'd1);
    check("flush_idle_busy", {31'd0, busy}, 32'd0);
    check("flush_drained", exp_q.size(), 32'd0);
    evt_valid = 1'b0;
    enable    = 1'b0;
    flush     = 1'b0;
    tick();

    // Asynchronous reset mid-STREAM with two events buffered.
    exp_seq   = 4'h0;
    enable    = 1'b1;
    evt_valid = 1'b1;
    evt_props = 4'hC;
    wait_run(30, seen);
    repeat (2) tick();
    evt_valid = 1'b0;
    tick();
    check("buffered_before_reset", exp_q.size(), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_reset", {31'd0, mon_reset}, 32'd1);
    check("arst_run", {31'd0, mon_run}, 32'd0);
    check("arst_sym", {24'd0, mon_symbols}, 32'h00);
    check("arst_ready", {31'd0, evt_ready}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    enable = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    exp_seq   = 4'h0;
    enable    = 1'b1;
    evt_valid = 1'b1;
    evt_props = 4'h9;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) break;
    end
    evt_valid = 1'b0;
    wait_run(30, seen);
    if (seen) check("new_session_sym", {24'd0, mon_symbols}, 32'h90);
    end_session();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ltl_symbol_encoder.md
# ltl_symbol_encoder

Producer side of the runtime-monitor symbol stream. Accepts 4-bit atomic-proposition events from core trace logic over a valid/ready handshake, buffers them, and packs each into an 8-bit symbol. Emits the symbols with the run/reset sequencing the monitor automata need, so the first symbol of a session coincides with the automata's start-of-data cycle. Sits between core commit/trace taps and the monitor cluster instances.

## Interface
- FIFO_DEPTH, 4, event buffer entries; power of two, ≥2
- RST_CYCLES, 2, minimum cycles mon_reset_o is held high per session start; ≥2
- clk_i  in  1  core clock; all logic on rising edge
- rst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  level; request a monitoring session
- flush_i  in  1  level; end the session after draining
- evt_valid_i  in  1  event valid
- evt_ready_o  out  1  event accepted when valid&ready
- evt_props_i  in  4  proposition vector p[3:0]
- mon_reset_o  out  1  monitor reset, active-high
- mon_run_o  out  1  symbol-valid strobe to monitor
- mon_symbols_o  out  8  symbol to monitor
- busy_o  out  1  high in any state except IDLE

## Operation
- Symbol format: mon_symbols_o = {props[3:0], seq[3:0]}. seq is a 4-bit emit counter; it is 0 for the first symbol of a session, +1 per emitted symbol, and wraps 15→0. The automata match ranges are 16-aligned, so seq is transparent to them.
- FSM states: IDLE, MRST, STREAM, DRAIN.
- IDLE:
  - mon_reset_o=1, evt_ready_o=0, FIFO empty.
  - enable_i=1 and flush_i=0 → MRST.
- MRST:
  - mon_reset_o=1; a cycle counter counts up to RST_CYCLES; seq is cleared.
  - evt_ready_o = !full.
  - When count ≥ RST_CYCLES and the FIFO is non-empty → STREAM. In that same transition the head is popped and emitted, and mon_reset_o drops, so symbol 0 lands on start-of-data.
  - flush_i → IDLE with the FIFO cleared.
- STREAM:
  - mon_reset_o=0; evt_ready_o = !full.
  - Each cycle with the FIFO non-empty: pop, register the symbol, mon_run_o=1 for one cycle.
  - Empty cycle: mon_run_o=0 and mon_symbols_o holds its last value.
  - flush_i → DRAIN.
- DRAIN:
  - evt_ready_o=0; pop and emit until empty, then → IDLE (mon_reset_o=1 the following cycle).
  - enable_i is ignored in DRAIN.
- Boundary conditions:
  - Full FIFO: evt_ready_o=0 even if a pop occurs in the same cycle; there is no pass-through.
  - Simultaneous push and pop when not full: both occur and occupancy is unchanged.
  - enable_i and flush_i both high in IDLE: stay in IDLE (flush wins).
  - enable_i low in STREAM has no effect; only flush_i ends a session.
  - rst_ni asserted mid-session: immediate return to IDLE, FIFO pointers cleared, outputs at reset values.

## Timing
- Reset values: mon_reset_o=1, mon_run_o=0, mon_symbols_o=8'h00, evt_ready_o=0, busy_o=0.
- Outputs mon_run_o, mon_symbols_o and mon_reset_o are registered.
- Latency: an event accepted at edge t with the FIFO empty in STREAM appears on mon_symbols_o with mon_run_o=1 after edge t+1.
- Session start: enable_i high at edge 0 → MRST at edge 1. mon_reset_o falls no earlier than edge 1+RST_CYCLES, and only once an event is buffered.
- Throughput: one symbol per cycle sustained.

## Configuration
- LTL_ENC_STATS_EN defined: adds two outputs, both cleared on entry to MRST and both saturating at all-ones.
  - sym_count_o[31:0]: symbols emitted in the session.
  - stall_count_o[31:0]: cycles with evt_valid_i=1 and evt_ready_o=0 in MRST/STREAM.
- Undefined: both ports and their counters are absent; all other behaviour is identical.

## Structure
- Package ltl_enc_pkg holds:
  - the state enum (IDLE, MRST, STREAM, DRAIN);
  - constants SYM_W=8, PROP_W=4, SEQ_W=4;
  - function build_symbol(props, seq).
- One sub-module, ltl_enc_fifo: synchronous FIFO with push/pop/full/empty/clear, depth FIFO_DEPTH, using an extra pointer bit to distinguish full from empty.

## Test plan
- Reset with enable_i=0 → mon_reset_o=1, mon_run_o=0, mon_symbols_o=0x00, evt_ready_o=0 indefinitely.
- enable_i=1, then one event props=4'hA at cycle 5 → mon_reset_o falls in the same cycle mon_run_o=1 with mon_symbols_o=0xA0.
- 20 back-to-back events props=4'h3, monitor always accepting → 20 consecutive mon_run_o pulses; symbols 0x30..0x3F, then 0x30..0x33 (seq wrap).
- FIFO_DEPTH=4, 6 events presented while still in MRST (RST_CYCLES=8) → evt_ready_o low after 4 accepts; the remaining 2 are accepted once streaming; all 6 are emitted in order.
- flush_i with 3 buffered events → evt_ready_o=0 immediately; 3 more mon_run_o pulses; then IDLE and mon_reset_o=1.
- rst_ni pulsed low mid-STREAM with 2 events buffered → outputs return to reset values asynchronously; the next session's first symbol carries seq=0.
